// File: rtl/dct_row_serializer.sv
// Double-banked row buffer: captures an 8-word coefficient row in parallel and
// streams it out one word per cycle on a ready/valid port.
module dct_row_serializer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic [WIDTH-1:0] I2,
    input  logic [WIDTH-1:0] I3,
    input  logic [WIDTH-1:0] I4,
    input  logic [WIDTH-1:0] I5,
    input  logic [WIDTH-1:0] I6,
    input  logic [WIDTH-1:0] I7,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_index,
    output logic             out_last,
    output logic             overflow
);

    logic [WIDTH-1:0] bank_q [2][8];
    logic [WIDTH-1:0] row_in [8];

    logic       wp_q, wp_d;
    logic       rp_q, rp_d;
    logic [1:0] count_q, count_d;
    logic [2:0] rd_idx_q, rd_idx_d;
    logic       overflow_q, overflow_d;

    logic capture, drop, xfer, bank_done;

    always_comb begin
        row_in[0] = I0;
        row_in[1] = I1;
        row_in[2] = I2;
        row_in[3] = I3;
        row_in[4] = I4;
        row_in[5] = I5;
        row_in[6] = I6;
        row_in[7] = I7;
    end

    // in_ready looks only at the registered count, so a bank freed this cycle
    // is not reusable until the next one.
    always_comb begin
        in_ready  = (count_q < 2'd2) && !reset;
        out_valid = (count_q != 2'd0);
        capture   = in_valid && in_ready;
        drop      = in_valid && !in_ready && !reset;
        xfer      = out_valid && out_ready;
        bank_done = xfer && (rd_idx_q == 3'd7);
    end

    always_comb begin
        wp_d       = wp_q;
        rp_d       = rp_q;
        count_d    = count_q;
        rd_idx_d   = rd_idx_q;
        overflow_d = overflow_q | drop;

        if (capture) begin
            wp_d = ~wp_q;
        end
        if (xfer) begin
            rd_idx_d = rd_idx_q + 3'd1;
        end
        if (bank_done) begin
            rp_d = ~rp_q;
        end

        unique case ({capture, bank_done})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q       <= 1'b0;
            rp_q       <= 1'b0;
            count_q    <= 2'd0;
            rd_idx_q   <= 3'd0;
            overflow_q <= 1'b0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            count_q    <= count_d;
            rd_idx_q   <= rd_idx_d;
            overflow_q <= overflow_d;
        end
    end

    // Bank contents need no reset; out_data is gated while nothing is valid.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int k = 0; k < 8; k++) begin
                bank_q[wp_q][k] <= row_in[k];
            end
        end
    end

    always_comb begin
        out_data  = out_valid ? bank_q[rp_q][rd_idx_q] : '0;
        out_index = rd_idx_q;
        out_last  = out_valid && (rd_idx_q == 3'd7);
        overflow  = overflow_q;
    end

endmodule
